// File: rtl/rr_arb16_pkg.sv
// rr_arb16 shared constants and state encoding.
// Imported by the arbiter top and its priority encoder.
package rr_arb16_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb16_pri_en16.sv
// 16-input priority encoder: highest set bit wins.
// hit is low and which is zero when no input is set.
module pri_en16
  import rr_arb16_pkg::*;
(
  input  logic [N_REQ-1:0] inp,
  output logic [IDX_W-1:0] which,
  output logic             hit
);

  always_comb begin
    which = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (inp[i]) which = IDX_W'(i);
    end
  end

  assign hit = |inp;

endmodule

// File: rtl/rr_arb16.sv
// Round-robin arbiter for 16 requesters with hold-until-done,
// timeout revocation and a programmable turnaround gap.
module rr_arb16
  import rr_arb16_pkg::*;
#(
  parameter int GAP    = 1,
  parameter int TMO_W  = 12,
  parameter int TMO_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam logic [3:0] GAP_LAST =
    (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t           r_state, w_state_nxt;
  logic [TMO_W-1:0] r_cnt, w_cnt_nxt;
  logic [3:0]       r_gcnt, w_gcnt_nxt;
  logic [IDX_W-1:0] r_last, w_last_nxt;
  logic [N_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_to, w_to_nxt;

  logic [N_REQ-1:0] w_mask;
  logic [N_REQ-1:0] w_lo;
  logic [IDX_W-1:0] w_lo_idx;
  logic [IDX_W-1:0] w_req_idx;
  logic [IDX_W-1:0] w_win;
  logic             w_lo_hit;
  logic             w_req_hit;
  logic             w_own_req;
  logic             w_expire;
  logic             w_rel;

  // Requesters strictly below the last owner get first pick.
  assign w_mask = (N_REQ'(1) << r_last) - N_REQ'(1);
  assign w_lo   = req & w_mask;

  pri_en16 u_pe_lo (
    .inp   (w_lo),
    .which (w_lo_idx),
    .hit   (w_lo_hit)
  );

  pri_en16 u_pe_req (
    .inp   (req),
    .which (w_req_idx),
    .hit   (w_req_hit)
  );

  assign w_win     = w_lo_hit ? w_lo_idx : w_req_idx;
  assign w_own_req = req[r_idx];
  assign w_expire  = (TMO_EN != 0) && (r_cnt == '1);
  assign w_rel     = done | ~w_own_req | w_expire;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_gcnt_nxt  = r_gcnt;
    w_last_nxt  = r_last;
    w_gnt_nxt   = r_gnt;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_to_nxt    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_req_hit) begin
          w_idx_nxt   = w_win;
          w_last_nxt  = w_win;
          w_gnt_nxt   = N_REQ'(1) << w_win;
          w_valid_nxt = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_rel) begin
          w_gnt_nxt   = '0;
          w_valid_nxt = 1'b0;
          w_to_nxt    = w_expire & ~done & w_own_req;
          w_gcnt_nxt  = '0;
          w_state_nxt = (GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_GAP: begin
        if (r_gcnt == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gcnt_nxt = r_gcnt + 4'd1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_last  <= '0;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gcnt  <= w_gcnt_nxt;
      r_last  <= w_last_nxt;
      r_gnt   <= w_gnt_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_to    <= w_to_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = r_valid;
  assign timeout   = r_to;

endmodule

// File: tb/tb_rr_arb16.sv
// Self-checking bench for rr_arb16: vector table, corner
// sequences and a random run against a cycle model.
module tb_rr_arb16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] req = '0;
  logic        done = 1'b0;

  logic [15:0] gnt0, gnt1;
  logic [3:0]  idx0, idx1;
  logic        v0, v1, to0, to1;

  always #5 clk = ~clk;

  rr_arb16 #(.GAP(1), .TMO_W(4), .TMO_EN(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(v0),
    .timeout(to0)
  );

  rr_arb16 #(.GAP(0), .TMO_W(4), .TMO_EN(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt(gnt1), .gnt_idx(idx1), .gnt_valid(v1),
    .timeout(to1)
  );

  typedef struct {
    int st; int cnt; int gc; int last; int idx;
    bit v; bit to;
  } mst_t;

  typedef struct {
    logic [21:0] o0;
    logic [21:0] o1;
  } exp_t;

  typedef struct {
    logic [15:0] r; logic d;
    logic [3:0] idx; logic v; logic to;
  } vec_t;

  localparam int TMAX = 15;

  exp_t sbq[$];
  mst_t m0, m1;
  vec_t tbl[12];
  int   errs = 0;
  int   checks = 0;

  function automatic mst_t mreset();
    mst_t s;
    s.st = 0; s.cnt = 0; s.gc = 0; s.last = 0; s.idx = 0;
    s.v = 0; s.to = 0;
    return s;
  endfunction

  function automatic mst_t mstep(mst_t s, logic [15:0] r,
                                 logic d, int gap);
    mst_t n;
    int w;
    n = s;
    n.to = 0;
    w = -1;
    case (s.st)
      0: begin
        for (int i = s.last - 1; i >= 0; i--)
          if (r[i] && w < 0) w = i;
        for (int i = 15; i >= 0; i--)
          if (r[i] && w < 0) w = i;
        if (w >= 0) begin
          n.idx = w; n.last = w; n.v = 1;
          n.cnt = 0; n.st = 1;
        end
      end
      1: begin
        if (d || !r[s.idx] || s.cnt == TMAX) begin
          n.v = 0;
          n.to = !d && r[s.idx];
          n.gc = 0;
          n.st = (gap > 0) ? 2 : 0;
        end else begin
          n.cnt = s.cnt + 1;
        end
      end
      default: begin
        if (s.gc == gap - 1) n.st = 0;
        else n.gc = s.gc + 1;
      end
    endcase
    return n;
  endfunction

  function automatic logic [21:0] mout(mst_t s);
    logic [15:0] g;
    g = s.v ? (16'h1 << s.idx) : 16'h0;
    return {g, 4'(s.idx), s.v, s.to};
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    exp_t e;
    m0 = mstep(m0, req, done, 1);
    m1 = mstep(m1, req, done, 0);
    e.o0 = mout(m0);
    e.o1 = mout(m1);
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("sb_u0", {gnt0, idx0, v0, to0}, e.o0);
    chk("sb_u1", {gnt1, idx1, v1, to1}, e.o1);
  endtask

  task automatic rst();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_u0", {gnt0, idx0, v0, to0}, 0);
    chk("rst_u1", {gnt1, idx1, v1, to1}, 0);
    m0 = mreset();
    m1 = mreset();
    sbq.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_v(input int which, input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((which == 0) ? v0 : v1) break;
      step();
    end
    chk("wait_valid", (which == 0) ? v0 : v1, 1);
  endtask

  initial begin
    int busy;
    int low;
    logic [15:0] eg;

    tbl[0]  = '{16'h8001, 1'b0, 4'd15, 1'b1, 1'b0};
    tbl[1]  = '{16'h8001, 1'b1, 4'd15, 1'b0, 1'b0};
    tbl[2]  = '{16'h8001, 1'b0, 4'd15, 1'b0, 1'b0};
    tbl[3]  = '{16'h8001, 1'b0, 4'd0,  1'b1, 1'b0};
    tbl[4]  = '{16'h8001, 1'b1, 4'd0,  1'b0, 1'b0};
    tbl[5]  = '{16'h0000, 1'b0, 4'd0,  1'b0, 1'b0};
    tbl[6]  = '{16'h0000, 1'b0, 4'd0,  1'b0, 1'b0};
    tbl[7]  = '{16'h0080, 1'b0, 4'd7,  1'b1, 1'b0};
    tbl[8]  = '{16'h0080, 1'b0, 4'd7,  1'b1, 1'b0};
    tbl[9]  = '{16'h0000, 1'b0, 4'd7,  1'b0, 1'b0};
    tbl[10] = '{16'h0000, 1'b0, 4'd7,  1'b0, 1'b0};
    tbl[11] = '{16'h0000, 1'b0, 4'd7,  1'b0, 1'b0};

    m0 = mreset();
    m1 = mreset();
    @(posedge clk);
    #1;
    rst();

    for (int i = 0; i < 12; i++) begin
      req  = tbl[i].r;
      done = tbl[i].d;
      step();
      eg = tbl[i].v ? (16'h1 << tbl[i].idx) : 16'h0;
      chk("tbl_idx", idx0, tbl[i].idx);
      chk("tbl_valid", v0, tbl[i].v);
      chk("tbl_gnt", gnt0, eg);
      chk("tbl_timeout", to0, tbl[i].to);
    end
    done = 1'b0;

    rst();
    req = 16'hFFFF;
    for (int k = 0; k < 17; k++) begin
      wait_v(0, 6);
      chk("rr_order", idx0, (k < 16) ? 15 - k : 15);
      chk("rr_onehot", $onehot(gnt0), 1);
      done = 1'b1;
      step();
      done = 1'b0;
    end

    rst();
    req = 16'h0004;
    wait_v(0, 4);
    busy = 0;
    while (v0 && busy < 40) begin
      busy++;
      chk("tmo_early", to0, 0);
      step();
    end
    chk("tmo_busy", busy, 16);
    chk("tmo_pulse", to0, 1);
    req = 16'h0000;
    step();
    chk("tmo_once", to0, 0);

    rst();
    req = 16'h0004;
    wait_v(0, 4);
    repeat (15) step();
    chk("coinc_pre", v0, 1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("coinc_valid", v0, 0);
    chk("coinc_timeout", to0, 0);

    rst();
    req = 16'hFFFF;
    wait_v(0, 4);
    done = 1'b1;
    step();
    done = 1'b0;
    wait_v(0, 6);
    chk("pre_rst_idx", idx0, 14);
    step();
    step();
    rst();
    wait_v(0, 4);
    chk("post_rst_idx", idx0, 15);

    rst();
    req = 16'h0011;
    for (int k = 0; k < 3; k++) begin
      wait_v(1, 6);
      chk("gap0_order", idx1, (k == 1) ? 0 : 4);
      done = 1'b1;
      step();
      done = 1'b0;
      if (k < 2) begin
        low = 0;
        while (!v1 && low < 10) begin
          low++;
          step();
        end
        chk("gap0_low", low, 1);
      end
    end

    rst();
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) req = 16'h0;
      else req = 16'($urandom) & 16'($urandom);
      done = ($urandom_range(0, 7) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
